// File: rtl/fix_signmult_seq.sv
// Sequential signed fixed-point multiplier: shift-add over operand magnitudes, then round-half-up and saturate.
// Optional early exit in CALC is enabled by defining FIX_SIGNMULT_EARLY_EXIT_EN.
module fix_signmult_seq #(
    parameter int INPUT_WIDTH  = 16,
    parameter int FRAC_BITS    = 8,
    parameter int OUTPUT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  multiplicand,
    input  logic [INPUT_WIDTH-1:0]  multiplier,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] result,
    output logic                    overflow,
    output logic                    busy
);

    localparam int AW     = 2 * INPUT_WIDTH;
    localparam int SW     = AW + 2;
    localparam int CW     = $clog2(INPUT_WIDTH + 1);
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

    localparam logic signed [SW-1:0] RND   = (FRAC_BITS > 0) ? (SW'(1) << RND_SH) : SW'(0);
    localparam logic signed [SW-1:0] R_MAX = (SW'(1) << (OUTPUT_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] R_MIN = -(SW'(1) << (OUTPUT_WIDTH - 1));
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [AW-1:0]            acc_r;
    logic [AW-1:0]            a_sh_r;
    logic [INPUT_WIDTH-1:0]   b_r;
    logic                     sign_r;
    logic [CW-1:0]            count_r;
    logic [INPUT_WIDTH-1:0]   a_mag_s;
    logic [INPUT_WIDTH-1:0]   b_mag_s;
    logic                     calc_last_s;
    logic                     skip_calc_s;
    logic [OUTPUT_WIDTH:0]    fix_s;
    logic                     in_ready_s;
    logic                     busy_s;
    logic                     out_valid_s;

    // Sign-apply, round half toward +inf, then clamp; returns {overflow, result}.
    function automatic logic [OUTPUT_WIDTH:0] round_sat(input logic neg, input logic [AW-1:0] mag);
        logic signed [SW-1:0]  p;
        logic signed [SW-1:0]  r;
        logic [OUTPUT_WIDTH:0] res;
        if (neg) begin
            p = -$signed({2'b00, mag});
        end else begin
            p = $signed({2'b00, mag});
        end
        r = (p + RND) >>> FRAC_BITS;
        if (r > R_MAX) begin
            res = {1'b1, SAT_MAX};
        end else if (r < R_MIN) begin
            res = {1'b1, SAT_MIN};
        end else begin
            res = {1'b0, r[OUTPUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    // Operand magnitudes; negating the most negative value wraps to the exact unsigned 2^(W-1).
    always_comb begin
        a_mag_s = multiplicand;
        b_mag_s = multiplier;
        if (multiplicand[INPUT_WIDTH-1]) begin
            a_mag_s = ~multiplicand + INPUT_WIDTH'(1);
        end else begin
            a_mag_s = multiplicand;
        end
        if (multiplier[INPUT_WIDTH-1]) begin
            b_mag_s = ~multiplier + INPUT_WIDTH'(1);
        end else begin
            b_mag_s = multiplier;
        end
    end

    // Decide when the shift-add loop may stop.
    always_comb begin
        calc_last_s = 1'b0;
        skip_calc_s = 1'b0;
`ifdef FIX_SIGNMULT_EARLY_EXIT_EN
        calc_last_s = (count_r == CW'(INPUT_WIDTH - 1)) || (b_r[INPUT_WIDTH-1:1] == '0);
        skip_calc_s = (b_mag_s == '0);
`else
        calc_last_s = (count_r == CW'(INPUT_WIDTH - 1));
        skip_calc_s = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = skip_calc_s ? FIX : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (calc_last_s) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:  state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the handshake flags are registered alongside it.
    always_comb begin
        in_ready_s  = 1'b0;
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
        case (state_s)
            IDLE:    in_ready_s  = 1'b1;
            CALC:    busy_s      = 1'b1;
            FIX:     busy_s      = 1'b1;
            DONE:    out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    // Shift-add datapath: operands are captured on accept and consumed one multiplier bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            a_sh_r  <= '0;
            b_r     <= '0;
            sign_r  <= 1'b0;
            count_r <= '0;
        end else if (state_r == IDLE && in_valid) begin
            acc_r   <= '0;
            a_sh_r  <= {{INPUT_WIDTH{1'b0}}, a_mag_s};
            b_r     <= b_mag_s;
            sign_r  <= multiplicand[INPUT_WIDTH-1] ^ multiplier[INPUT_WIDTH-1];
            count_r <= '0;
        end else if (state_r == CALC) begin
            if (b_r[0]) begin
                acc_r <= acc_r + a_sh_r;
            end else begin
                acc_r <= acc_r;
            end
            a_sh_r  <= a_sh_r << 1;
            b_r     <= b_r >> 1;
            count_r <= count_r + CW'(1);
        end else begin
            acc_r   <= acc_r;
            a_sh_r  <= a_sh_r;
            b_r     <= b_r;
            sign_r  <= sign_r;
            count_r <= count_r;
        end
    end

    assign fix_s = round_sat(sign_r, acc_r);

    // Registered outputs; result and overflow change only when leaving FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            in_ready  <= in_ready_s;
            busy      <= busy_s;
            out_valid <= out_valid_s;
            if (state_r == FIX) begin
                overflow <= fix_s[OUTPUT_WIDTH];
                result   <= fix_s[OUTPUT_WIDTH-1:0];
            end else begin
                overflow <= overflow;
                result   <= result;
            end
        end
    end

endmodule

// File: tb/tb_fix_signmult_seq.sv
// Directed self-checking bench for fix_signmult_seq at the default 16/8/16 configuration.
module tb_fix_signmult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    fix_signmult_seq #(.INPUT_WIDTH(16), .FRAC_BITS(8), .OUTPUT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected accept-to-out_valid latency for a given multiplier.
    function automatic int exp_lat(input logic [15:0] b);
`ifdef FIX_SIGNMULT_EARLY_EXIT_EN
        logic [15:0] m;
        int hi;
        m  = b[15] ? (~b + 16'd1) : b;
        hi = -1;
        for (int i = 0; i < 16; i++) if (m[i]) hi = i;
        return (hi < 0) ? 1 : hi + 2;
`else
        return 17;
`endif
    endfunction

    // Wait (bounded) until out_valid is seen #1 after an edge; counts edges since the accept edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        multiplicand = 16'h0000; multiplier = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, overflow, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b ov=%b res=%h, need 1 0 0 0 0000",
                     in_ready, out_valid, busy, overflow, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic eov, input string name);
        int g;
        int lat;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        multiplicand = a; multiplier = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        multiplicand = 16'($urandom); multiplier = 16'($urandom);
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: busy=%b rdy=%b, need 1 0", name, busy, in_ready);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== exp_lat(b)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d need %0d", name, lat, exp_lat(b));
        end
        n_cmp++;
        if (result !== er || overflow !== eov) begin
            n_fail++;
            $display("FAIL %s result: got %h ov=%b need %h ov=%b", name, result, overflow, er, eov);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== er || overflow !== eov) begin
            n_fail++;
            $display("FAIL %s handshake: vld=%b rdy=%b res=%h ov=%b, need 0 1 %h %b",
                     name, out_valid, in_ready, result, overflow, er, eov);
        end
    endtask

    task automatic test_basic();
        run_txn(16'h0100, 16'h0280, 16'h0280, 1'b0, "one_x_2p5");
        run_txn(16'hC090, 16'h004B, 16'hED6A, 1'b0, "neg_mixed");
        run_txn(16'h0000, 16'h1234, 16'h0000, 1'b0, "zero_a");
        run_txn(16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, "max_exact");
        run_txn(16'h8000, 16'h0100, 16'h8000, 1'b0, "min_exact");
    endtask

    task automatic test_saturation();
        run_txn(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "sat_pos");
        run_txn(16'h8000, 16'h7FFF, 16'h8000, 1'b1, "sat_neg");
        run_txn(16'h8000, 16'h8000, 16'h7FFF, 1'b1, "sat_minmin");
    endtask

    task automatic test_rounding();
        run_txn(16'h0001, 16'h0080, 16'h0001, 1'b0, "rnd_half_pos");
        run_txn(16'hFFFF, 16'h0080, 16'h0000, 1'b0, "rnd_half_neg");
        run_txn(16'h0001, 16'h007F, 16'h0000, 1'b0, "rnd_below");
    endtask

    task automatic test_early_exit();
        run_txn(16'h0100, 16'h0003, 16'h0003, 1'b0, "ee_b3");
        run_txn(16'h1234, 16'h0000, 16'h0000, 1'b0, "ee_b0");
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        @(negedge clk);
        multiplicand = 16'h0100; multiplier = 16'h0280; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        n_cmp++;
        if (out_valid !== 1'b1 || result !== 16'h0280) begin
            n_fail++;
            $display("FAIL bp_first: vld=%b res=%h, need 1 0280", out_valid, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            multiplicand = 16'h0300; multiplier = 16'h0200; in_valid = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || result !== 16'h0280 || overflow !== 1'b0 ||
                in_ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b res=%h ov=%b rdy=%b busy=%b, need 1 0280 0 0 0",
                         i, out_valid, result, overflow, in_ready, busy);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b busy=%b, need 0 1 0", out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_accept: busy=%b rdy=%b, need 1 0", busy, in_ready);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== exp_lat(16'h0200) || result !== 16'h0600 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second: lat=%0d res=%h ov=%b, need %0d 0600 0",
                     lat, result, overflow, exp_lat(16'h0200));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        multiplicand = 16'h1234; multiplier = 16'h7FFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, overflow, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b ov=%b res=%h, need 1 0 0 0 0000",
                     in_ready, out_valid, busy, overflow, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(16'h0200, 16'h0300, 16'h0600, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_early_exit();
        test_backpressure();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
